// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display scanner:
// the sixteen glyph encodings (gfedcba order) and the decimal-point position.
package display_pkg;

   typedef logic [6:0] seg7_t;

   // Bit position of the decimal point inside the 8-bit segment bus {dp,g,f,e,d,c,b,a}.
   localparam int DP_BIT = 7;

   localparam seg7_t SEG_0     = 7'h3F;
   localparam seg7_t SEG_1     = 7'h06;
   localparam seg7_t SEG_2     = 7'h5B;
   localparam seg7_t SEG_3     = 7'h4F;
   localparam seg7_t SEG_4     = 7'h66;
   localparam seg7_t SEG_5     = 7'h6D;
   localparam seg7_t SEG_6     = 7'h7D;
   localparam seg7_t SEG_7     = 7'h07;
   localparam seg7_t SEG_8     = 7'h7F;
   localparam seg7_t SEG_9     = 7'h6F;
   localparam seg7_t SEG_A     = 7'h77;
   localparam seg7_t SEG_B     = 7'h7C;
   localparam seg7_t SEG_C     = 7'h39;
   localparam seg7_t SEG_D     = 7'h5E;
   localparam seg7_t SEG_E     = 7'h79;
   localparam seg7_t SEG_F     = 7'h71;
   localparam seg7_t SEG_BLANK = 7'h00;

   localparam seg7_t SEG_TABLE [16] = '{
      SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
      SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
   };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-7-segment decoder. With HEX_EN=0 the values 10..15
// render as a blank digit instead of A-F.
module seg7_decoder
   import display_pkg::*;
#(
   parameter bit HEX_EN = 1'b1
) (
   input  logic [3:0] value,
   output seg7_t      segments
);

   // Table lookup, blanked for the letter range when hex display is disabled.
   always_comb begin
      // NOTE: assign every always_comb output unconditionally first so no path leaves it unassigned (which would infer a latch).
      segments = SEG_TABLE[value];
      if (!HEX_EN && (value > 4'd9)) begin
         segments = SEG_BLANK;
      end
   end

endmodule

// File: rtl/display_scan.sv
// Multiplexed 7-segment display scanner. A slot counter time-slices the
// digits, a free-running 4-bit PWM counter dims them, and loaded data is
// double-buffered so a new value only appears from the start of a frame.
// All outputs are registered; polarity inversion is applied last.
module display_scan
   import display_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int BLANK_CYCLES   = 16,
   parameter bit HEX_EN         = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit DIG_ACTIVE_LOW = 1'b0
) (
   input  logic                  i_Clk,
   input  logic                  i_Reset,
   input  logic                  i_Load,
   input  logic [4*DIGITS-1:0]   i_Data,
   input  logic [DIGITS-1:0]     i_Enable_Digits,
   input  logic [DIGITS-1:0]     i_Dots,
   input  logic [3:0]            i_Brightness,
   output logic [7:0]            o_Segments,
   output logic [DIGITS-1:0]     o_Digits,
   output logic                  o_Frame_Start
);

   localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);

   // One complete display image: per-digit value, enable and decimal point.
   typedef struct packed {
      logic [DIGITS-1:0][3:0] value;
      logic [DIGITS-1:0]      enable;
      logic [DIGITS-1:0]      dots;
   } frame_t;

   logic [SLOT_W-1:0] slot_cnt;
   logic [IDX_W-1:0]  digit_idx;
   logic [3:0]        pwm_cnt;
   logic              slot_wrap;
   logic              frame_wrap;

   frame_t            pending;
   frame_t            active;

   logic              lit;
   logic [DIGITS-1:0] strobe;
   logic [3:0]        cur_value;
   seg7_t             cur_segs;
   logic [7:0]        seg_next;

   logic [7:0]        seg_q;
   logic [DIGITS-1:0] dig_q;
   logic              frame_q;

   // Slot end and frame end (last slot of the last digit) detection.
   always_comb begin
      slot_wrap  = (slot_cnt == SLOT_LAST);
      frame_wrap = slot_wrap && (digit_idx == IDX_LAST);
   end

   // Slot, digit index and PWM counters.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         slot_cnt  <= '0;
         digit_idx <= '0;
         pwm_cnt   <= '0;
      end else begin
         pwm_cnt  <= pwm_cnt + 4'd1;
         slot_cnt <= slot_wrap ? '0 : slot_cnt + SLOT_W'(1);
         if (slot_wrap) begin
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
         end
      end
   end

   // Double buffer: loads land in pending, pending moves to active at frame end.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         // NOTE: the image buffers are plain registers, so reset clears them; after reset every digit is disabled until the next load.
         pending <= '0;
         active  <= '0;
      end else begin
         // NOTE: non-blocking assignments make active take the old pending even when a load lands on the same edge.
         if (frame_wrap) begin
            active <= pending;
         end
         if (i_Load) begin
            pending.value  <= i_Data;
            pending.enable <= i_Enable_Digits;
            pending.dots   <= i_Dots;
         end
      end
   end

   // Strobe qualification: selected, enabled, past dead time and inside PWM duty.
   always_comb begin
      strobe    = '0;
      lit       = active.enable[digit_idx] && (slot_cnt >= SLOT_BLANK) &&
                  (pwm_cnt <= i_Brightness);
      cur_value = active.value[digit_idx];
      if (lit) begin
         strobe[digit_idx] = 1'b1;
      end
   end

   seg7_decoder #(
      .HEX_EN (HEX_EN)
   ) u_decoder (
      .value    (cur_value),
      .segments (cur_segs)
   );

   // Segment bus assembly; dark whenever no digit is strobed.
   always_comb begin
      seg_next = '0;
      if (lit) begin
         seg_next[6:0]    = cur_segs;
         seg_next[DP_BIT] = active.dots[digit_idx];
      end
   end

   // Output registers, one cycle behind the counter state that selects them.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         seg_q   <= '0;
         dig_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         seg_q   <= seg_next;
         dig_q   <= strobe;
         frame_q <= (slot_cnt == '0) && (digit_idx == '0);
      end
   end

   assign o_Segments    = seg_q ^ {8{SEG_ACTIVE_LOW}};
   assign o_Digits      = dig_q ^ {DIGITS{DIG_ACTIVE_LOW}};
   assign o_Frame_Start = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan. Two instances share stimulus:
// dut_a is active-high with hex letters, dut_b is active-low with letters
// blanked. A cycle-indexed reference model derives the expected outputs
// directly from elapsed cycles since reset.
module tb_display_scan;

   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 8;
   localparam int BLANK    = 2;
   localparam int FRAME    = DIGITS * SCAN_DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] data = '0;
   logic [3:0]  en = '0;
   logic [3:0]  dots = '0;
   logic [3:0]  bri = '0;

   logic [7:0]  seg_a, seg_b;
   logic [3:0]  dig_a, dig_b;
   logic        fs_a, fs_b;

   always #5 clk = ~clk;

   display_scan #(
      .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK),
      .HEX_EN(1'b1), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
   ) dut_a (
      .i_Clk(clk), .i_Reset(rst), .i_Load(load), .i_Data(data),
      .i_Enable_Digits(en), .i_Dots(dots), .i_Brightness(bri),
      .o_Segments(seg_a), .o_Digits(dig_a), .o_Frame_Start(fs_a)
   );

   display_scan #(
      .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK),
      .HEX_EN(1'b0), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
   ) dut_b (
      .i_Clk(clk), .i_Reset(rst), .i_Load(load), .i_Data(data),
      .i_Enable_Digits(en), .i_Dots(dots), .i_Brightness(bri),
      .o_Segments(seg_b), .o_Digits(dig_b), .o_Frame_Start(fs_b)
   );

   typedef struct {
      logic [15:0] data;
      logic [3:0]  en;
      logic [3:0]  dots;
   } image_t;

   localparam logic [6:0] FONT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   int     total = 0;
   int     bad = 0;
   int     n = 0;
   image_t pend, act;
   logic [7:0] exp_seg_a, exp_seg_b;
   logic [3:0] exp_dig_a, exp_dig_b;
   logic       exp_fs;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h cycle=%0d t=%0t", tag, got, want, n, $time);
      end
   endtask

   // Is the digit selected in cycle k visibly lit?
   function automatic bit ref_lit(input int k, input image_t f, input logic [3:0] b);
      int slot, idx, pwm;
      slot = k % SCAN_DIV;
      idx  = (k / SCAN_DIV) % DIGITS;
      pwm  = k % 16;
      return f.en[idx] && (slot >= BLANK) && (pwm <= int'(b));
   endfunction

   function automatic logic [7:0] ref_seg(input int k, input image_t f, input logic [3:0] b,
                                          input bit hex);
      int idx;
      logic [3:0] v;
      idx = (k / SCAN_DIV) % DIGITS;
      v   = f.data[idx*4 +: 4];
      if (!ref_lit(k, f, b)) return 8'h00;
      return {f.dots[idx], (hex || v < 4'd10) ? FONT[v] : 7'h00};
   endfunction

   function automatic logic [3:0] ref_dig(input int k, input image_t f, input logic [3:0] b);
      int idx;
      idx = (k / SCAN_DIV) % DIGITS;
      if (!ref_lit(k, f, b)) return 4'b0000;
      return 4'(1 << idx);
   endfunction

   task automatic check_outputs();
      check("seg_a", 32'(seg_a), 32'(exp_seg_a));
      check("dig_a", 32'(dig_a), 32'(exp_dig_a));
      check("fs_a",  32'(fs_a),  32'(exp_fs));
      check("seg_b", 32'(seg_b), 32'(exp_seg_b));
      check("dig_b", 32'(dig_b), 32'(exp_dig_b));
      check("fs_b",  32'(fs_b),  32'(exp_fs));
   endtask

   // One clock: check previous outputs, drive inputs, advance the model.
   task automatic cycle(input bit ld, input logic [15:0] d, input logic [3:0] e,
                        input logic [3:0] p, input logic [3:0] b);
      @(negedge clk);
      check_outputs();
      load = ld; data = d; en = e; dots = p; bri = b;
      exp_seg_a = ref_seg(n, act, b, 1'b1);
      exp_seg_b = ~ref_seg(n, act, b, 1'b0);
      exp_dig_a = ref_dig(n, act, b);
      exp_dig_b = ~ref_dig(n, act, b);
      exp_fs    = ((n % FRAME) == 0);
      if (((n + 1) % FRAME) == 0) act = pend;
      if (ld) pend = '{data: d, en: e, dots: p};
      n++;
   endtask

   task automatic idle(input int k, input logic [3:0] b);
      repeat (k) cycle(1'b0, data, en, dots, b);
   endtask

   task automatic run_to(input int pos);
      while ((n % FRAME) != pos) cycle(1'b0, data, en, dots, bri);
   endtask

   // Asynchronous reset mid-cycle: outputs must go inactive before any edge.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      load = 1'b0;
      #1;
      n = 0;
      pend = '{data: 16'h0, en: 4'h0, dots: 4'h0};
      act  = '{data: 16'h0, en: 4'h0, dots: 4'h0};
      exp_seg_a = 8'h00; exp_dig_a = 4'h0;
      exp_seg_b = 8'hFF; exp_dig_b = 4'hF;
      exp_fs = 1'b0;
      check_outputs();
      repeat (2) begin
         @(negedge clk);
         check_outputs();
      end
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      logic [3:0] rb;
      rb = 4'd15;

      do_reset();

      // Basic scan of 1234, full brightness.
      cycle(1'b1, 16'h1234, 4'hF, 4'h0, 4'd15);
      idle(3 * FRAME, 4'd15);

      // Mid-frame load of hex letters: held until the next frame.
      run_to(10);
      cycle(1'b1, 16'h00AB, 4'hF, 4'h0, 4'd15);
      idle(2 * FRAME, 4'd15);

      // Dimmed single digit showing 8.
      cycle(1'b1, 16'h0008, 4'h1, 4'h0, 4'd3);
      idle(2 * FRAME, 4'd3);

      // Sparse enables with one decimal point.
      cycle(1'b1, 16'h5678, 4'b0101, 4'b0100, 4'd15);
      idle(2 * FRAME, 4'd15);

      // Load on the frame boundary, then several loads in one frame.
      run_to(FRAME - 1);
      cycle(1'b1, 16'h9ABC, 4'hF, 4'b1010, 4'd15);
      idle(5, 4'd15);
      cycle(1'b1, 16'hDEF0, 4'hF, 4'h0, 4'd15);
      idle(3, 4'd15);
      cycle(1'b1, 16'h1357, 4'hE, 4'h1, 4'd0);
      idle(2 * FRAME, 4'd0);

      // Reset mid-frame with a pending value that must be discarded.
      cycle(1'b1, 16'h2468, 4'hF, 4'hF, 4'd15);
      run_to(13);
      do_reset();
      idle(2 * FRAME, 4'd15);

      // Randomised loads and brightness changes.
      for (int i = 0; i < 3000; i++) begin
         if ((i % 40) == 0) rb = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0)
            cycle(1'b1, 16'($urandom), 4'($urandom), 4'($urandom), rb);
         else
            cycle(1'b0, data, en, dots, rb);
      end

      @(negedge clk);
      check_outputs();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
